sync_debounce: RTL

Conditions a raw asynchronous or bouncy 1-bit input, such as a push-button or an off-chip strobe, into a clean, clock-aligned level. It also produces single-cycle edge pulses.
It sits directly upstream of the single-bit data registers in the sequential blocks and drives their i_data.

---
 rtl/sync_debounce.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sync_debounce.sv
// ---------------------------------------------------------------------------
// sync_debounce
//   Cleans up a raw, asynchronous or bouncy 1-bit input (push-button, off-chip
//   strobe) into a clock-aligned level with single-cycle edge pulses.
//   Datapath: synchronizer chain -> two-state debounce FSM with a stability
//   counter -> registered edge pulses.
//
// Parameters
//   SYNC_STAGES : flops in the input synchronizer chain (2..4)
//   CNT_MAX     : consecutive mismatching samples needed to change o_data (>=1)
//   RST_VAL     : reset value of the synchronizer flops and of o_data
//
// Ports
//   clk     in  system clock, rising edge
//   i_rst   in  asynchronous active-high reset
//   i_data  in  raw unsynchronized input
//   o_data  out debounced, synchronized level
//   o_rise  out one-cycle pulse when o_data goes 0->1
//   o_fall  out one-cycle pulse when o_data goes 1->0
//   o_busy  out high while the FSM is qualifying a change (CHECK)
// ---------------------------------------------------------------------------
module sync_debounce #(
   parameter int   SYNC_STAGES = 2,
   parameter int   CNT_MAX     = 1000,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_data,
   output logic o_data,
   output logic o_rise,
   output logic o_fall,
   output logic o_busy
);

   localparam int CNT_W = $clog2(CNT_MAX + 1);
   // Counter value at which the next mismatching sample completes the run.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   localparam logic [0:0] ST_STABLE = 1'b0;
   localparam logic [0:0] ST_CHECK  = 1'b1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_data;
   logic             r_rise;
   logic             r_fall;

   logic [0:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_data_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic             w_mismatch;

   // ---- stage: input synchronizer ----
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_data};
      end
   end

   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_mismatch = w_s ^ r_data;

   // ---- stage: debounce FSM next-state ----
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         ST_STABLE: begin
            w_cnt_nxt = '0;
            if (w_mismatch) begin
               if (CNT_MAX == 1) begin
                  // A single mismatching sample is already a full run.
                  w_data_nxt = w_s;
                  w_rise_nxt = w_s;
                  w_fall_nxt = ~w_s;
               end else begin
                  w_cnt_nxt   = CNT_W'(1);
                  w_state_nxt = ST_CHECK;
               end
            end
         end
         default: begin
            if (!w_mismatch) begin
               // Input bounced back before the run completed: discard it.
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STABLE;
            end else if (r_cnt == CNT_LAST) begin
               w_data_nxt  = w_s;
               w_rise_nxt  = w_s;
               w_fall_nxt  = ~w_s;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STABLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   // ---- stage: state, level and pulse registers ----
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_data  <= RST_VAL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // CHECK is encoded as 1, so the state flop doubles as the busy flag.
   assign o_busy = r_state[0];
   assign o_data = r_data;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule
